// File: rtl/clos_obuf_sync.sv
// clos_obuf_sync: captures 1-of-4 return-to-zero flits from a Clos CM output, acks them and queues them decoded.
// Define CLOS_OBUF_ERRCHK_EN to add the sticky err output for multi-hot sub-channels.
module clos_obuf_sync #(
  parameter int DW    = 8,
  parameter int SCN   = DW / 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*SCN-1:0]       di,
  input  logic                   di4,
  output logic                   dia,
  output logic                   dia4,
  output logic [DW-1:0]          do_data,
  output logic                   do_eof,
  output logic                   do_vld,
  input  logic                   do_rdy,
`ifdef CLOS_OBUF_ERRCHK_EN
  output logic                   err,
`endif
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 4 * SCN + 1;

  typedef enum logic [1:0] {S_NULL, S_CHK, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    sync1_q, sync2_q;
  logic [WW-1:0]    latch_q, latch_d;
  logic             dia_q, dia_d, dia4_q, dia4_d;
  logic [DW:0]      mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sComplete, sNull, full, push, pop;
  logic [DW:0]      headWord;
`ifdef CLOS_OBUF_ERRCHK_EN
  logic             sMulti, err_q, err_d;
`endif

  // Each sub-channel's one-hot position becomes two binary bits; multi-hot resolves to the lowest wire.
  function automatic logic [DW-1:0] decodeCode(input logic [4*SCN-1:0] code);
    logic [DW-1:0] res;
    logic [3:0]    c;
    res = '0;
    for (int k = 0; k < SCN; k++) begin
      c = code[4*k +: 4];
      if (c[0])      res[2*k +: 2] = 2'd0;
      else if (c[1]) res[2*k +: 2] = 2'd1;
      else if (c[2]) res[2*k +: 2] = 2'd2;
      else if (c[3]) res[2*k +: 2] = 2'd3;
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {di4, di};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin : completion
    logic [3:0] c;
    c         = '0;
    sComplete = 1'b1;
`ifdef CLOS_OBUF_ERRCHK_EN
    sMulti    = 1'b0;
`endif
    for (int k = 0; k < SCN; k++) begin
      c = sync2_q[4*k +: 4];
      if (c == 4'd0) sComplete = 1'b0;
`ifdef CLOS_OBUF_ERRCHK_EN
      if ((c & (c - 4'd1)) != 4'd0) sMulti = 1'b1;
`endif
    end
`ifdef CLOS_OBUF_ERRCHK_EN
    if (sMulti) sComplete = 1'b0;
`endif
  end

  assign sNull = (sync2_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign pop   = do_vld & do_rdy;

  // A code must be seen twice in a row (S_NULL then S_CHK) before it is trusted and pushed.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    dia_d   = dia_q;
    dia4_d  = dia4_q;
    push    = 1'b0;
`ifdef CLOS_OBUF_ERRCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_NULL: begin
`ifdef CLOS_OBUF_ERRCHK_EN
        if (sMulti) begin
          err_d   = 1'b1;
          dia_d   = 1'b1;
          dia4_d  = sync2_q[WW-1];
          state_d = S_ACK;
        end else
`endif
        if (sComplete) begin
          latch_d = sync2_q;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
`ifdef CLOS_OBUF_ERRCHK_EN
        if (sMulti) begin
          err_d   = 1'b1;
          dia_d   = 1'b1;
          dia4_d  = sync2_q[WW-1];
          state_d = S_ACK;
        end else
`endif
        if (sync2_q == latch_q) begin
          if (sComplete && !full) begin
            push    = 1'b1;
            dia_d   = 1'b1;
            dia4_d  = latch_q[WW-1];
            state_d = S_ACK;
          end
        end else if (sComplete) begin
          latch_d = sync2_q;
        end else begin
          state_d = S_NULL;
        end
      end
      S_ACK: begin
        if (sNull) begin
          dia_d   = 1'b0;
          dia4_d  = 1'b0;
          state_d = S_NULL;
        end
      end
      default: state_d = S_NULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NULL;
      latch_q <= '0;
      dia_q   <= 1'b0;
      dia4_q  <= 1'b0;
`ifdef CLOS_OBUF_ERRCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      dia_q   <= dia_d;
      dia4_q  <= dia4_d;
`ifdef CLOS_OBUF_ERRCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {latch_q[WW-1], decodeCode(latch_q[WW-2:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Head entry is masked while empty so stale or never-written storage is not visible.
  assign headWord = mem_q[rdPtr_q];
  assign do_vld   = (cnt_q != '0);
  assign do_data  = do_vld ? headWord[DW-1:0] : '0;
  assign do_eof   = do_vld ? headWord[DW] : 1'b0;
  assign fifo_cnt = cnt_q;
  assign dia      = dia_q;
  assign dia4     = dia4_q;
`ifdef CLOS_OBUF_ERRCHK_EN
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_clos_obuf_sync.sv
// Directed scoreboard bench for clos_obuf_sync (DW=8, DEPTH=4); a negedge monitor checks every popped flit.
module tb_clos_obuf_sync;

  localparam int DW    = 8;
  localparam int SCN   = DW / 2;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic [4*SCN-1:0]       di;
  logic                   di4;
  logic                   dia;
  logic                   dia4;
  logic [DW-1:0]          do_data;
  logic                   do_eof;
  logic                   do_vld;
  logic                   do_rdy;
  logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef CLOS_OBUF_ERRCHK_EN
  logic                   err;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [DW:0] expQ[$];

  clos_obuf_sync #(.DW(DW), .SCN(SCN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .di       (di),
    .di4      (di4),
    .dia      (dia),
    .dia4     (dia4),
    .do_data  (do_data),
    .do_eof   (do_eof),
    .do_vld   (do_vld),
    .do_rdy   (do_rdy),
`ifdef CLOS_OBUF_ERRCHK_EN
    .err      (err),
`endif
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head flit must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && do_vld && do_rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pop", {23'd0, do_eof, do_data}, 32'hFFFF_FFFF);
      end else begin
        logic [DW:0] e;
        e = expQ.pop_front();
        checkOutput("pop_data", {24'd0, do_data}, {24'd0, e[DW-1:0]});
        checkOutput("pop_eof", {31'd0, do_eof}, {31'd0, e[DW]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDia(input logic level, input int maxCycles, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    while (!done && n < maxCycles) begin
      step();
      n++;
      if (dia === level) done = 1'b1;
    end
    if (!done) checkOutput("dia_timeout", {31'd0, dia}, {31'd0, level});
  endtask

  task automatic applyStimulus(input logic [4*SCN-1:0] code, input logic eof,
                               input logic [DW-1:0] expData, input bit expectPush);
    di  = code;
    di4 = eof;
    if (expectPush) expQ.push_back({eof, expData});
  endtask

  task automatic releaseFlit(output int n);
    di  = '0;
    di4 = 1'b0;
    waitDia(1'b0, 20, n);
  endtask

  task automatic sendFlit(input logic [4*SCN-1:0] code, input logic eof, input logic [DW-1:0] expData);
    int n;
    applyStimulus(code, eof, expData, 1'b1);
    waitDia(1'b1, 20, n);
    checkOutput("send_dia4", {31'd0, dia4}, {31'd0, eof});
    releaseFlit(n);
    checkOutput("send_dia4_drop", {31'd0, dia4}, 32'd0);
  endtask

  task automatic drain();
    int n;
    do_rdy = 1'b1;
    n = 0;
    while (fifo_cnt != 0 && n < 20) begin
      step();
      n++;
    end
    do_rdy = 1'b0;
    checkOutput("drain_cnt", {29'd0, fifo_cnt}, 32'd0);
    checkOutput("empty_data", {23'd0, do_eof, do_data}, 32'd0);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    di     = '0;
    di4    = 1'b0;
    do_rdy = 1'b0;
    step(); step(); step();
    checkOutput("rst_dia", {31'd0, dia}, 32'd0);
    checkOutput("rst_dia4", {31'd0, dia4}, 32'd0);
    checkOutput("rst_vld", {31'd0, do_vld}, 32'd0);
    checkOutput("rst_cnt", {29'd0, fifo_cnt}, 32'd0);
    checkOutput("rst_out", {23'd0, do_eof, do_data}, 32'd0);
`ifdef CLOS_OBUF_ERRCHK_EN
    checkOutput("rst_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;
    step();

    $display("[TB] single flit latency");
    applyStimulus(16'h1248, 1'b0, 8'h1B, 1'b1);
    waitDia(1'b1, 20, n);
    checkOutput("ack_latency", n, 32'd4);
    checkOutput("single_dia4", {31'd0, dia4}, 32'd0);
    checkOutput("single_vld", {31'd0, do_vld}, 32'd1);
    checkOutput("single_cnt", {29'd0, fifo_cnt}, 32'd1);
    releaseFlit(n);
    checkOutput("release_latency", n, 32'd3);
    drain();

    $display("[TB] eof flit and data change while acked");
    applyStimulus(16'h8421, 1'b1, 8'hE4, 1'b1);
    waitDia(1'b1, 20, n);
    checkOutput("eof_dia4", {31'd0, dia4}, 32'd1);
    di  = 16'h1111;
    di4 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checkOutput("violation_dia", {31'd0, dia}, 32'd1);
    checkOutput("violation_cnt", {29'd0, fifo_cnt}, 32'd1);
    releaseFlit(n);
    checkOutput("eof_dia4_drop", {31'd0, dia4}, 32'd0);
    drain();

    $display("[TB] full back-pressure");
    sendFlit(16'h1111, 1'b0, 8'h00);
    sendFlit(16'h2222, 1'b0, 8'h55);
    sendFlit(16'h4444, 1'b1, 8'hAA);
    sendFlit(16'h8888, 1'b0, 8'hFF);
    applyStimulus(16'h1248, 1'b0, 8'h1B, 1'b1);
    for (int i = 0; i < 10; i++) step();
    checkOutput("bp_blocked_dia", {31'd0, dia}, 32'd0);
    checkOutput("bp_full_cnt", {29'd0, fifo_cnt}, 32'd4);
    do_rdy = 1'b1;
    step();
    do_rdy = 1'b0;
    checkOutput("bp_after_pop_cnt", {29'd0, fifo_cnt}, 32'd3);
    step();
    checkOutput("bp_5th_dia", {31'd0, dia}, 32'd1);
    checkOutput("bp_5th_cnt", {29'd0, fifo_cnt}, 32'd4);
    releaseFlit(n);
    drain();

    $display("[TB] simultaneous push and pop");
    sendFlit(16'h2222, 1'b0, 8'h55);
    sendFlit(16'h4444, 1'b1, 8'hAA);
    applyStimulus(16'h8888, 1'b0, 8'hFF, 1'b1);
    step(); step(); step();
    do_rdy = 1'b1;
    step();
    do_rdy = 1'b0;
    checkOutput("pp_dia", {31'd0, dia}, 32'd1);
    checkOutput("pp_cnt", {29'd0, fifo_cnt}, 32'd2);
    releaseFlit(n);
    drain();

    $display("[TB] reset mid-handshake");
    sendFlit(16'h1111, 1'b0, 8'h00);
    sendFlit(16'h2222, 1'b0, 8'h55);
    applyStimulus(16'h4444, 1'b1, 8'hAA, 1'b1);
    waitDia(1'b1, 20, n);
    checkOutput("pre_rst_cnt", {29'd0, fifo_cnt}, 32'd3);
    rst = 1'b1;
    di  = '0;
    di4 = 1'b0;
    step();
    checkOutput("midrst_dia", {31'd0, dia}, 32'd0);
    checkOutput("midrst_dia4", {31'd0, dia4}, 32'd0);
    checkOutput("midrst_vld", {31'd0, do_vld}, 32'd0);
    checkOutput("midrst_cnt", {29'd0, fifo_cnt}, 32'd0);
    rst = 1'b0;
    expQ.delete();
    for (int i = 0; i < 6; i++) step();
    checkOutput("postrst_idle", {31'd0, dia}, 32'd0);
    sendFlit(16'h8421, 1'b0, 8'hE4);
    drain();

`ifdef CLOS_OBUF_ERRCHK_EN
    $display("[TB] illegal multi-hot code");
    checkOutput("err_clear", {31'd0, err}, 32'd0);
    applyStimulus(16'h1243, 1'b0, 8'h00, 1'b0);
    waitDia(1'b1, 20, n);
    checkOutput("err_set", {31'd0, err}, 32'd1);
    checkOutput("err_no_push", {29'd0, fifo_cnt}, 32'd0);
    releaseFlit(n);
    sendFlit(16'h1248, 1'b0, 8'h1B);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
    drain();
    checkOutput("err_sticky_end", {31'd0, err}, 32'd1);
`else
    $display("[TB] multi-hot decodes to lowest wire");
    sendFlit(16'h124B, 1'b0, 8'h18);
    drain();
`endif

    checkOutput("scoreboard_empty", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
